sm_alu_arbiter: RTL and testbench
=================================

# sm_alu_arbiter

Shares one sign-magnitude add/subtract core between two requesters. A round-robin arbiter grants one requester, latches its operands, runs the core and returns a registered result with overflow and compare flags. It sits between the two operand sources and the combinational sign-magnitude datapath, and is the only block that drives that datapath.

## Interface
- W, 4, magnitude width in bits; sign is a separate bit.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- req  in  2  per-requester request; held high with operands stable until the matching done pulse.
- am0, bm0 / am1, bm1  in  W each  A and B magnitudes, requester 0 / 1.
- as0, bs0 / as1, bs1  in  1 each  A and B signs (1 = negative), requester 0 / 1.
- op0 / op1  in  1 each  1 = A+B, 0 = A−B.
- gnt  out  2  one-hot grant; high during EXEC and RESP for the served requester.
- done  out  2  one-cycle pulse to the served requester in RESP.
- ym  out  W  result magnitude.
- ys  out  1  result sign.
- of  out  1  magnitude overflow.
- eq  out  1  signed A == B.
- lt  out  1  signed A < B.
- rsp_id  out  1  index of the requester that owns the current result.

## Operation
- FSM states are IDLE, EXEC and RESP. Transitions: IDLE→EXEC when any req is high; EXEC→RESP always; RESP→IDLE always.
- Arbitration happens in IDLE:
  - If only one req is high, that requester wins.
  - If both are high, the requester not granted last time wins. The last-grant pointer resets to 1, so requester 0 wins the first tie.
- On IDLE→EXEC the block latches the winner's operands and op into internal registers. Later operand changes have no effect on the current operation.
- EXEC: the core sees the latched operands. At the end of EXEC the block registers ym, ys, of, eq, lt and rsp_id.
- Arithmetic:
  - Effective B sign is bs ^ ~op.
  - Same signs: ym = (am+bm) mod 2^W, ys = as, of = carry out.
  - Different signs: ym = larger magnitude − smaller magnitude, ys = sign of the larger, of = 0.
  - A zero result always has ys = 0 (no negative zero).
- Compare flags use the operands A and B, not the result, and ignore op. +0 and −0 compare equal.
- Result outputs hold their values until the next RESP update.
- Requester rules:
  - Drop req at the edge that samples done=1, or keep req high with new operands to issue back-to-back.
  - A req still high in IDLE is treated as a new request.

## Timing
- Reset values: FSM = IDLE; gnt, done, ym, ys, of, eq, lt, rsp_id all 0; last-grant pointer = 1.
- A req sampled at edge t produces:
  - gnt high in cycles t+1 and t+2;
  - done and valid results in cycle t+2.
- Latency is 2 cycles. Throughput is 1 operation per 3 cycles, shared across both requesters.
- With both req high continuously, grants alternate 0,1,0,1… The loser waits at most 3 cycles before its operation starts.
- If reset asserts during EXEC or RESP, the operation is abandoned and all outputs clear at once (asynchronously). No done pulse is issued.
- req changes during EXEC or RESP are ignored until the next IDLE.

## Configuration
- SM_SATURATE_EN defined: when of=1, ym is forced to all ones (2^W−1); of and ys are unchanged.
- SM_SATURATE_EN undefined: when of=1, ym holds the wrapped sum (mod 2^W).

## Structure
- Package sm_pkg holds:
  - the W default;
  - the state enum (IDLE, EXEC, RESP);
  - the sm_operand_t struct (mag, sign);
  - the sm_result_t struct (ym, ys, of, eq, lt).
- Sub-module sm_addsub holds the combinational sign-magnitude add/sub and compare core. It is instantiated once. The arbiter, operand registers and FSM live in sm_alu_arbiter.

## Test plan
- req0 only, +3 + +2 (op=1) → done0 at t+2, ym=5, ys=0, of=0, eq=0, lt=0, rsp_id=0.
- req1 only, +14 + +3 → of=1, ys=0, lt=0. Without SM_SATURATE_EN ym=1; with it ym=15.
- req0, −3 − (−2) (op=0) → ym=1, ys=1; +0 − +0 → ym=0, ys=0, eq=1.
- Both req held high for 12 cycles, with requester 0 adding +15 + −15 and requester 1 adding −3 + +2:
  - grants must be 0,1,0,1;
  - requester 0 results: ym=0, ys=0;
  - requester 1 results: ym=1, ys=1, lt=1.
- Reset asserted during EXEC → gnt and done clear immediately, no done pulse; the next tie after reset is granted to requester 0.
- Back-to-back on req0 with operands changed on the done edge → second result reflects the new operands 3 cycles after the first done.

Source files
------------

// File: rtl/sm_pkg.sv
// Shared width, FSM states and operand/result records for the sign-magnitude ALU arbiter.
package sm_pkg;

  localparam int W = 4;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  typedef struct packed {
    logic         sign;
    logic [W-1:0] mag;
  } sm_operand_t;

  typedef struct packed {
    logic [W-1:0] ym;
    logic         ys;
    logic         of;
    logic         eq;
    logic         lt;
  } sm_result_t;

endpackage

// File: rtl/sm_addsub.sv
// Combinational sign-magnitude add/subtract and signed compare core.
// Define SM_SATURATE_EN to clamp an overflowing magnitude to all ones.
module sm_addsub
  import sm_pkg::*;
(
  input  sm_operand_t a,
  input  sm_operand_t b,
  input  logic        op,
  output sm_result_t  res
);

  logic         eff_bs;
  logic [W:0]   sum;
  logic         a_neg;
  logic         b_neg;

  // NOTE: every output gets a default first so no path through this block infers a latch.
  always_comb begin
    res    = '0;
    eff_bs = b.sign ^ ~op;
    sum    = {1'b0, a.mag} + {1'b0, b.mag};

    if (a.sign == eff_bs) begin
      res.ym = sum[W-1:0];
      res.ys = a.sign;
      res.of = sum[W];
    end else if (a.mag >= b.mag) begin
      res.ym = a.mag - b.mag;
      res.ys = a.sign;
    end else begin
      res.ym = b.mag - a.mag;
      res.ys = eff_bs;
    end

`ifdef SM_SATURATE_EN
    if (res.of) res.ym = '1;
`endif

    // A genuine zero is always positive; a wrapped overflow keeps its sign.
    if (!res.of && res.ym == '0) res.ys = 1'b0;

    // Compare the operands themselves; -0 is folded into +0.
    a_neg = a.sign & (a.mag != '0);
    b_neg = b.sign & (b.mag != '0);
    res.eq = (a_neg == b_neg) && (a.mag == b.mag);
    if (a_neg != b_neg) res.lt = a_neg;
    else if (!a_neg)    res.lt = a.mag < b.mag;
    else                res.lt = a.mag > b.mag;
  end

endmodule

// File: rtl/sm_alu_arbiter.sv
// Round-robin arbiter sharing one sm_addsub core between two requesters.
// Saturation of overflowing results is selected by SM_SATURATE_EN in sm_addsub.
module sm_alu_arbiter
  import sm_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic [1:0]   req,
  input  logic [W-1:0] am0,
  input  logic [W-1:0] bm0,
  input  logic         as0,
  input  logic         bs0,
  input  logic         op0,
  input  logic [W-1:0] am1,
  input  logic [W-1:0] bm1,
  input  logic         as1,
  input  logic         bs1,
  input  logic         op1,
  output logic [1:0]   gnt,
  output logic [1:0]   done,
  output logic [W-1:0] ym,
  output logic         ys,
  output logic         of,
  output logic         eq,
  output logic         lt,
  output logic         rsp_id
);

  state_t      state_q, state_d;
  logic        last_q;
  logic        id_q;
  logic        win;
  logic        rsp_id_q;
  sm_operand_t a_q, b_q;
  logic        op_q;
  sm_result_t  core_res, res_q;

  always_comb begin
    case (req)
      2'b01:   win = 1'b0;
      2'b10:   win = 1'b1;
      default: win = ~last_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|req) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  sm_addsub u_core (
    .a   (a_q),
    .b   (b_q),
    .op  (op_q),
    .res (core_res)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      id_q     <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= 1'b0;
      res_q    <= '0;
      rsp_id_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && |req) begin
        id_q   <= win;
        last_q <= win;
        a_q    <= win ? sm_operand_t'{as1, am1} : sm_operand_t'{as0, am0};
        b_q    <= win ? sm_operand_t'{bs1, bm1} : sm_operand_t'{bs0, bm0};
        op_q   <= win ? op1 : op0;
      end
      if (state_q == EXEC) begin
        res_q    <= core_res;
        rsp_id_q <= id_q;
      end
    end
  end

  // Grant and done decode straight from the state register, so reset clears them at once.
  assign gnt    = (state_q != IDLE) ? {id_q, ~id_q} : 2'b00;
  assign done   = (state_q == RESP) ? {id_q, ~id_q} : 2'b00;
  assign ym     = res_q.ym;
  assign ys     = res_q.ys;
  assign of     = res_q.of;
  assign eq     = res_q.eq;
  assign lt     = res_q.lt;
  assign rsp_id = rsp_id_q;

endmodule

// File: tb/tb_sm_alu_arbiter.sv
// Self-checking bench for sm_alu_arbiter: directed table, random ops against a model, multi-cycle corners.
module tb_sm_alu_arbiter;

`ifdef SM_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct {
    logic [3:0] ym;
    logic       ys;
    logic       of;
    logic       eq;
    logic       lt;
  } exp_t;

  typedef struct {
    int         id;
    logic [3:0] am;
    logic       a_s;
    logic [3:0] bm;
    logic       b_s;
    logic       op;
    exp_t       e;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] req;
  logic [3:0] am0, bm0, am1, bm1;
  logic       as0, bs0, op0, as1, bs1, op1;
  logic [1:0] gnt, done;
  logic [3:0] ym;
  logic       ys, of, eq, lt, rsp_id;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  sm_alu_arbiter dut (
    .clk(clk), .reset(reset), .req(req),
    .am0(am0), .bm0(bm0), .as0(as0), .bs0(bs0), .op0(op0),
    .am1(am1), .bm1(bm1), .as1(as1), .bs1(bs1), .op1(op1),
    .gnt(gnt), .done(done), .ym(ym), .ys(ys), .of(of),
    .eq(eq), .lt(lt), .rsp_id(rsp_id)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: evaluate with signed integers, then derive magnitude/sign/overflow.
  function automatic exp_t model(input logic [3:0] am, input logic a_s,
                                 input logic [3:0] bm, input logic b_s, input logic op);
    exp_t e;
    int va, vb, vbe, s, mag;
    va  = a_s ? -int'(am) : int'(am);
    vb  = b_s ? -int'(bm) : int'(bm);
    vbe = op ? vb : -vb;
    s   = va + vbe;
    mag = (s < 0) ? -s : s;
    e.of = (mag > 15);
    e.ym = (e.of && SAT) ? 4'hf : 4'(mag % 16);
    e.ys = (s < 0);
    e.eq = (va == vb);
    e.lt = (va < vb);
    return e;
  endfunction

  task automatic drive(input int id, input logic [3:0] am, input logic a_s,
                       input logic [3:0] bm, input logic b_s, input logic op);
    if (id == 0) begin am0 = am; as0 = a_s; bm0 = bm; bs0 = b_s; op0 = op; end
    else         begin am1 = am; as1 = a_s; bm1 = bm; bs1 = b_s; op1 = op; end
  endtask

  task automatic check_res(input string tag, input exp_t e, input int id);
    check({tag, "_ym"}, ym, e.ym);
    check({tag, "_ys"}, ys, e.ys);
    check({tag, "_of"}, of, e.of);
    check({tag, "_eq"}, eq, e.eq);
    check({tag, "_lt"}, lt, e.lt);
    check({tag, "_rsp_id"}, rsp_id, id);
  endtask

  // Single request from idle; checks grant/done timing and the registered result.
  task automatic run_op(input string tag, input int id, input logic [3:0] am, input logic a_s,
                        input logic [3:0] bm, input logic b_s, input logic op, input exp_t e);
    logic [1:0] oh;
    oh = (id == 0) ? 2'b01 : 2'b10;
    @(negedge clk);
    drive(id, am, a_s, bm, b_s, op);
    req = oh;
    @(negedge clk);
    drive(id, ~am, ~a_s, ~bm, ~b_s, ~op);
    check({tag, "_gnt_exec"}, gnt, oh);
    check({tag, "_done_exec"}, done, 2'b00);
    @(negedge clk);
    check({tag, "_gnt_resp"}, gnt, oh);
    check({tag, "_done_resp"}, done, oh);
    check_res(tag, e, id);
    req = 2'b00;
    @(negedge clk);
    check({tag, "_gnt_idle"}, gnt, 2'b00);
    check({tag, "_done_idle"}, done, 2'b00);
  endtask

  vec_t tbl[7];

  initial begin
    exp_t e;
    int k;
    int id;
    logic [3:0] ra, rb;
    logic rsa, rsb, rop;

    tbl[0] = '{0, 4'd3,  1'b0, 4'd2,  1'b0, 1'b1, '{4'd5, 1'b0, 1'b0, 1'b0, 1'b0}};
    tbl[1] = '{1, 4'd14, 1'b0, 4'd3,  1'b0, 1'b1, '{SAT ? 4'd15 : 4'd1, 1'b0, 1'b1, 1'b0, 1'b0}};
    tbl[2] = '{0, 4'd3,  1'b1, 4'd2,  1'b1, 1'b0, '{4'd1, 1'b1, 1'b0, 1'b0, 1'b1}};
    tbl[3] = '{0, 4'd0,  1'b0, 4'd0,  1'b0, 1'b0, '{4'd0, 1'b0, 1'b0, 1'b1, 1'b0}};
    tbl[4] = '{1, 4'd0,  1'b1, 4'd0,  1'b0, 1'b1, '{4'd0, 1'b0, 1'b0, 1'b1, 1'b0}};
    tbl[5] = '{0, 4'd15, 1'b1, 4'd15, 1'b1, 1'b1, '{SAT ? 4'd15 : 4'd14, 1'b1, 1'b1, 1'b1, 1'b0}};
    tbl[6] = '{1, 4'd7,  1'b0, 4'd9,  1'b1, 1'b0, '{SAT ? 4'd15 : 4'd0, 1'b0, 1'b1, 1'b0, 1'b0}};

    reset = 1'b1;
    req   = 2'b00;
    drive(0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    drive(1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check("rst_gnt", gnt, 2'b00);
    check("rst_done", done, 2'b00);
    check("rst_res", {ym, ys, of, eq, lt, rsp_id}, 0);
    reset = 1'b0;

    for (int i = 0; i < 7; i++)
      run_op($sformatf("tbl%0d", i), tbl[i].id, tbl[i].am, tbl[i].a_s,
             tbl[i].bm, tbl[i].b_s, tbl[i].op, tbl[i].e);

    for (int i = 0; i < 40; i++) begin
      id  = int'($urandom_range(1, 0));
      ra  = 4'($urandom); rb = 4'($urandom);
      rsa = 1'($urandom); rsb = 1'($urandom); rop = 1'($urandom);
      run_op($sformatf("rnd%0d", i), id, ra, rsa, rb, rsb, rop, model(ra, rsa, rb, rsb, rop));
    end

    // Ties: fresh reset puts the pointer at 1, so requester 0 is served first.
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    drive(0, 4'd15, 1'b0, 4'd15, 1'b1, 1'b1);
    drive(1, 4'd3,  1'b1, 4'd2,  1'b0, 1'b1);
    req = 2'b11;
    k = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done != 2'b00) begin
        check("tie_done", done, (k % 2) ? 2'b10 : 2'b01);
        check("tie_gnt", gnt, (k % 2) ? 2'b10 : 2'b01);
        if (k % 2) check_res("tie_r1", '{4'd1, 1'b1, 1'b0, 1'b0, 1'b1}, 1);
        else       check_res("tie_r0", '{4'd0, 1'b0, 1'b0, 1'b0, 1'b0}, 0);
        k++;
      end
    end
    req = 2'b00;
    check("tie_count", k, 4);
    @(negedge clk);

    // Reset during EXEC abandons the op with no done pulse.
    drive(1, 4'd5, 1'b0, 4'd1, 1'b0, 1'b1);
    req = 2'b10;
    @(negedge clk);
    check("abort_gnt_exec", gnt, 2'b10);
    #2 reset = 1'b1;
    #1;
    check("abort_gnt", gnt, 2'b00);
    check("abort_done", done, 2'b00);
    check("abort_ym", ym, 4'd0);
    req = 2'b00;
    #1 reset = 1'b0;
    k = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (done != 2'b00) k++;
    end
    check("abort_no_done", k, 0);
    req = 2'b11;
    @(negedge clk);
    check("post_rst_tie_gnt", gnt, 2'b01);
    @(negedge clk);
    check("post_rst_tie_done", done, 2'b01);
    req = 2'b00;
    @(negedge clk);

    // Back-to-back on requester 0 with new operands presented on the done edge.
    drive(0, 4'd1, 1'b0, 4'd1, 1'b0, 1'b1);
    req = 2'b01;
    repeat (2) @(negedge clk);
    check("b2b_done1", done, 2'b01);
    check_res("b2b_r1", '{4'd2, 1'b0, 1'b0, 1'b1, 1'b0}, 0);
    drive(0, 4'd5, 1'b0, 4'd7, 1'b0, 1'b0);
    k = 0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (done == 2'b01 && k == 0) k = c;
    end
    check("b2b_gap", k, 3);
    check_res("b2b_r2", '{4'd2, 1'b1, 1'b0, 1'b0, 1'b1}, 0);
    req = 2'b00;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
